// File: rtl/gate_pkg.sv
// Shared types for the gate-unit arbiter: gate op encoding and controller states.
package gate_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int               j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < N; i++) begin
      j  = (int'(ptr) + i) % N;
      jj = IDX_W'(j);
      if (!grant_vld && req[jj]) begin
        grant[jj] = 1'b1;
        grant_idx = jj;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin front end for one shared gate unit: accept one request, hold operands
// for GU_LAT cycles, capture the result and hold it tagged with the requester id.
module gate_unit_arbiter
  import gate_pkg::*;
#(
  parameter int BIT_LEN = 8,
  parameter int NUM_REQ = 4,
  parameter int GU_LAT  = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*2-1:0]       req_op,
  input  logic [NUM_REQ*BIT_LEN-1:0] req_a,
  input  logic [NUM_REQ*BIT_LEN-1:0] req_b,
  output logic                       gu_valid,
  output logic [1:0]                 gu_op,
  output logic [BIT_LEN-1:0]         gu_a,
  output logic [BIT_LEN-1:0]         gu_b,
  input  logic [BIT_LEN-1:0]         gu_c,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [BIT_LEN-1:0]         resp_data
);

  if (GU_LAT < 1) begin : g_bad_lat
    $error("gate_unit_arbiter: GU_LAT must be >= 1");
  end
  if (NUM_REQ < 2) begin : g_bad_req
    $error("gate_unit_arbiter: NUM_REQ must be >= 2");
  end

  // Counter runs GU_LAT-1 .. 0 across the BUSY cycles; zero marks the sampling cycle.
  localparam int CNT_W = (GU_LAT > 1) ? $clog2(GU_LAT) : 1;

  arb_state_e           state, state_nxt;
  logic [ID_W-1:0]      ptr, id_q;
  gate_op_e             op_q;
  logic [BIT_LEN-1:0]   a_q, b_q, res_q;
  logic [CNT_W-1:0]     cnt;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_vld;
  logic                 accept;
  logic                 lat_done;
  logic [1:0]           sel_op;
  logic [BIT_LEN-1:0]   sel_a, sel_b;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // One-hot grant steers the winning requester's payload.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[i*BIT_LEN +: BIT_LEN];
        sel_b  = req_b[i*BIT_LEN +: BIT_LEN];
      end
    end
  end

  assign lat_done = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: if (grant_vld) begin
        accept    = 1'b1;
        state_nxt = ST_BUSY;
      end
      ST_BUSY: if (lat_done)   state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      id_q  <= '0;
      op_q  <= OP_AND;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        op_q <= gate_op_e'(sel_op);
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= grant_idx;
        cnt  <= CNT_W'(GU_LAT - 1);
        ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else if (state == ST_BUSY && !lat_done) begin
        cnt <= cnt - 1'b1;
      end
      if (state == ST_BUSY && lat_done) res_q <= gu_c;
    end
  end

  // Reset gates req_ready so nothing looks accepted while rst_n is low.
  assign req_ready  = (rst_n && state == ST_IDLE) ? grant : '0;
  assign gu_valid   = (state == ST_BUSY);
  assign gu_op      = op_q;
  assign gu_a       = a_q;
  assign gu_b       = b_q;
  assign resp_valid = (state == ST_RESP);
  assign resp_id    = id_q;
  assign resp_data  = res_q;

endmodule
